// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding, default
// word width and the counter-width helper.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Number of bits needed to hold the values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Synchronous-clear up-counter that stops at LIMIT and flags it on tc.
// Used by the serializer to mark the final data bit of a frame.
module bit_counter
  import piso_pkg::*;
#(
  parameter int               CNT_W = 3,
  parameter logic [CNT_W-1:0] LIMIT = '1
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  // Count up while enabled; hold at LIMIT so the value never wraps.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == LIMIT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: WIDTH-bit words in on a valid/ready
// handshake, MSB-first bit stream out with ser_valid / ser_last framing.
// Optional feature macro: PISO_SERIALIZER_PARITY_EN appends an even-parity
// bit after the data bits of every frame.
//
// Handshake: a word transfers at a rising edge where load_valid && load_ready.
// load_ready never depends on load_valid; the upstream holds load_data stable
// until the transfer happens.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_d,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int               CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             rdy_en;
  logic             accept;
  logic             tc;
  logic             cnt_clr;
  logic             cnt_en;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  assign accept = load_valid && load_ready;

  // Counter restarts on reset, on every new word and after the final data bit.
  assign cnt_clr = rst || accept || tc;
  assign cnt_en  = (state == SHIFT);

  bit_counter #(
    .CNT_W (CNT_W),
    .LIMIT (LAST_IDX)
  ) u_bit_counter (
    .clk (clk),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (tc)
  );

  // Main FSM: loads words, shifts the data out MSB first and chains frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      rdy_en <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      rdy_en <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= load_data;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_q <= ^load_data;
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (tc) begin
            if (accept) begin
              // Back-to-back frame: reload on the final bit, no idle gap.
              shreg <= load_data;
`ifdef PISO_SERIALIZER_PARITY_EN
              par_q <= ^load_data;
`endif
            end else begin
              shreg <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
`endif
            end
          end else begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
          end
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        PARITY: begin
          if (accept) begin
            shreg <= load_data;
            par_q <= ^load_data;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode, taken only from registers.
`ifdef PISO_SERIALIZER_PARITY_EN
  assign ser_last = (state == PARITY);
  assign ser_d    = (state == SHIFT)  ? shreg[WIDTH-1] :
                    (state == PARITY) ? par_q : 1'b0;
`else
  assign ser_last = tc;
  assign ser_d    = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
`endif
  assign ser_valid  = (state != IDLE);
  assign busy       = ser_valid;
  assign load_ready = rdy_en && ((state == IDLE) || ser_last);
  assign dbg_state  = state;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer (WIDTH = 8): scoreboard of expected serial bits,
// table of words captured frame by frame, and hand sequences for streaming,
// stalled upstream and mid-frame reset.
module tb_piso_serializer;
  import piso_pkg::*;

  localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         load_ready;
  logic         ser_d;
  logic         ser_valid;
  logic         ser_last;
  logic         busy;
  state_t       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;
  logic rst_at_edge = 1'b1;

  // {d, last} per expected serial cycle
  logic [1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] data;
    logic         exp_par;
  } vec_t;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .ser_d      (ser_d),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset tracking
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rst_at_edge <= rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
`ifdef PISO_SERIALIZER_PARITY_EN
      exp_q.push_back({w[i], 1'b0});
`else
      exp_q.push_back({w[i], (i == 0)});
`endif
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    exp_q.push_back({^w, 1'b1});
`endif
  endfunction

  // scoreboard monitor: compare the shown bit, then record any accept
  always @(negedge clk) begin : mon
    logic [1:0] cur;
    logic       exp_ready;
    if (started) begin
      exp_ready = !rst_at_edge && ((exp_q.size() == 0) || exp_q[0][0]);
      chk("load_ready", load_ready, exp_ready);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("ser_valid", ser_valid, 1);
        chk("busy", busy, 1);
        chk("ser_d", ser_d, cur[1]);
        chk("ser_last", ser_last, cur[0]);
      end else begin
        chk("idle_ser_valid", ser_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ser_d", ser_d, 0);
        chk("idle_ser_last", ser_last, 0);
      end
      if (rst) exp_q.delete();
      else if (load_valid && load_ready) push_word(load_data);
    end
  end

  // driver: present a word and wait for acceptance; called #1 after posedge
  task automatic send(input logic [W-1:0] w, input bit keep, output int waited);
    bit ok;
    load_data  = w;
    load_valid = 1'b1;
    waited     = 0;
    do begin
      @(negedge clk);
      ok = load_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!ok && waited < 200);
    if (!ok) chk("accept_timeout", 0, 1);
    if (!keep) begin
      load_valid = 1'b0;
      load_data  = W'($urandom);
    end
  endtask

  // collect one frame from the serial pins, ending on ser_last
  task automatic capture(output logic [15:0] acc, output int len);
    int cyc = 0;
    acc = '0;
    len = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (ser_valid) begin
        acc = {acc[14:0], ser_d};
        len++;
      end
    end while (!(ser_valid && ser_last) && cyc < 40);
    if (cyc >= 40) chk("capture_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while ((exp_q.size() != 0 || ser_valid) && cyc < 100);
    if (cyc >= 100) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    vec_t       vecs[8];
    int         waited;
    logic [15:0] acc;
    int         len;
    logic [W-1:0] word;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h03, 1'b0};
    vecs[3] = '{8'h3C, 1'b0};
    vecs[4] = '{8'h81, 1'b0};
    vecs[5] = '{8'h5A, 1'b0};
    vecs[6] = '{8'h01, 1'b1};
    vecs[7] = '{8'hFE, 1'b1};

    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    @(posedge clk);
    started = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_state", dbg_state, IDLE);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // idle for 20 cycles: monitor checks ready high and no serial activity
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("idle_ready_after_20", load_ready, 1);

    // table: single words, each captured and compared as a whole frame
    foreach (vecs[i]) begin
      send(vecs[i].data, 1'b0, waited);
      capture(acc, len);
      chk("frame_len", len, FRAME);
`ifdef PISO_SERIALIZER_PARITY_EN
      chk("frame_word", acc[8:1], vecs[i].data);
      chk("frame_parity", acc[0], vecs[i].exp_par);
`else
      chk("frame_word", acc[7:0], vecs[i].data);
`endif
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();

    // 0xFF then 0x00 held: second word taken on the closing cycle of the first
    send(8'hFF, 1'b1, waited);
    send(8'h00, 1'b0, waited);
    chk("b2b_wait", waited, FRAME);
    wait_idle();

    // upstream stalled while busy: 0x81 waits for load_ready
    send(8'h55, 1'b0, waited);
    send(8'h81, 1'b0, waited);
    chk("stall_wait", waited, FRAME);
    wait_idle();

    // reset during the 3rd bit of 0x3C
    send(8'h3C, 1'b0, waited);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ser_valid", ser_valid, 0);
    chk("abort_ser_last", ser_last, 0);
    chk("abort_ser_d", ser_d, 0);
    chk("abort_ready_low", load_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_ready_high", load_ready, 1);
    @(posedge clk);
    #1;
    repeat (12) begin
      @(posedge clk);
      #1;
    end

    // random stream, sometimes back-to-back
    for (int k = 0; k < 6; k++) begin
      word = W'($urandom_range(0, 255));
      send(word, bit'($urandom_range(0, 1)), waited);
    end
    load_valid = 1'b0;
    wait_idle();

    started = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmitter that turns WIDTH-bit words into an MSB-first single-bit stream with a qualifying valid strobe. It is the driving end of the serial D-line used by the flip-flop and shift-register receivers in the sequential library. Words enter on a valid/ready handshake. Back-to-back words stream with no idle gap.

## Interface
- WIDTH, 8, data word width in bits, ≥ 2
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- load_data  input  WIDTH  parallel word to transmit
- load_valid  input  1  load_data is valid
- load_ready  output  1  block accepts a word this cycle
- ser_d  output  1  serial data bit, MSB first
- ser_valid  output  1  ser_d carries a frame bit
- ser_last  output  1  final bit of the current frame
- busy  output  1  frame in progress, equal to ser_valid

## Operation
- Reset values: state IDLE, shift register 0, bit counter 0, ser_d 0, ser_valid 0, ser_last 0, busy 0, load_ready 0. load_ready rises in the first cycle after rst falls.
- Accept: a word transfers at a rising edge where load_valid && load_ready.
- load_ready = (state == IDLE) || ser_last.
  - The block accepts while idle.
  - The block also accepts on the final bit cycle of a frame.
- States:
  - IDLE: ser_valid 0, ser_d 0. On accept, load the shift register and clear the counter, then go to SHIFT.
  - SHIFT: ser_d = shift register MSB and ser_valid = 1. Each edge shifts left by one, fills with 0 and increments the counter. When counter == WIDTH-1, ser_last = 1.
  - On the last edge of SHIFT:
    - If a word is accepted, reload, clear the counter and stay in SHIFT.
    - Otherwise go to IDLE, or to PARITY when PARITY_EN is defined.
- Rules on ser_d and the counter:
  - ser_d is 0 whenever ser_valid is 0.
  - The counter is clog2(WIDTH) bits wide.
  - The counter compares against WIDTH-1 only and never wraps past it.
- load_data and load_valid are ignored while load_ready is 0. The upstream holds its word until accepted.
- Reset mid-frame aborts the frame.
  - Outputs return to reset values at the next edge.
  - No partial frame resumes.
  - The aborted frame never shows ser_last.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Latency: word accepted at edge N → MSB on ser_d during the cycle after edge N.
- A frame occupies WIDTH consecutive ser_valid cycles, or WIDTH+1 with PARITY_EN.
- Throughput: with load_valid held high, words stream continuously. ser_valid stays 1 across frame boundaries, with ser_last marking each final bit.
- If rst and load_valid are both high in the same cycle, rst wins and the word is not accepted.

## Configuration
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined:
  - A PARITY state follows the data bits.
  - In PARITY, ser_d = even-parity bit, which is the XOR of the accepted word, captured at load.
  - ser_valid = 1, ser_last = 1 and load_ready = 1. An accept in PARITY goes straight to SHIFT.
  - ser_last is 0 on the final data bit.
- Undefined:
  - There is no PARITY state and no parity register.
  - ser_last falls on data bit WIDTH-1.

## Structure
- Shared package piso_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY)
  - the default WIDTH constant
  - the counter-width function clog2
- One sub-module, bit_counter: a synchronous-clear up-counter with a terminal-count output at a parameterised limit. It drives ser_last.
- The shift register, parity register and FSM stay in the top module.

## Test plan
- WIDTH=8, reset then load 0xA5 for one cycle:
  - ser_d = 1,0,1,0,0,1,0,1 on 8 consecutive ser_valid cycles.
  - ser_last only on the 8th cycle, then ser_valid 0.
- Load 0xFF, then hold load_valid with 0x00 ready:
  - 0x00 is accepted on the ser_last cycle of 0xFF.
  - 16 contiguous ser_valid cycles: eight 1s then eight 0s.
- Assert rst during the 3rd bit of 0x3C:
  - Next cycle ser_valid, ser_last and ser_d are 0.
  - load_ready is 1 one cycle after rst falls.
  - No ser_last for the aborted frame.
- Present 0x81 with load_valid while a frame is busy:
  - The word is not taken until load_ready rises.
  - It is then transmitted intact: 1,0,0,0,0,0,0,1.
- With PISO_SERIALIZER_PARITY_EN, load 0x07:
  - 9-cycle frame whose 9th bit is 1.
  - ser_last only on the 9th bit.
  - Load 0x03 → 9th bit 0.
- Keep load_valid low for 20 cycles after reset: ser_valid, ser_last and busy stay 0, and load_ready stays 1.
